uart_tx: RTL

UART transmitter, the send-side counterpart of the team's serial receiver.
- Accepts an 8-bit byte via a start/busy handshake.
- Serialises it on `tx`: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Bit timing comes from an internal divider on the system clock, so no second clock domain exists.
- Sits between the host-side command logic and the board serial pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx.sv | 114 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: frame states,
// data width, idle line level and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    // Even parity makes the total count of ones even; odd parity makes it odd.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake and serial line of the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 start;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx;
    logic                 busy;
    logic                 done_t;

    modport master (output start, data_in, input tx, busy, done_t);
    modport slave  (input start, data_in, output tx, busy, done_t);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [2:0]           idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 tick;
    logic                 baud_clr;

    // Holding the divider clear while idle phase-aligns bit 0 to the accept edge.
    assign baud_clr = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr_i (baud_clr),
        .tick_o(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        shift_q <= bus.data_in;
                        par_q   <= parity_bit(bus.data_in, PARITY_ODD != 0);
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (idx_q == LAST_BIT) begin
                            idx_q <= '0;
                            if (PARITY_EN != 0) begin
                                tx_q    <= par_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= IDLE_LEVEL;
                                state_q <= STOP;
                            end
                        end else begin
                            // tx takes the next bit now, so it is read before the shift lands.
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            idx_q   <= idx_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx_q    <= IDLE_LEVEL;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (idx_q == LAST_STOP) begin
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx     = tx_q;
    assign bus.busy   = busy_q;
    assign bus.done_t = done_q;

endmodule
